bullet_scheduler: RTL and testbench
===================================

# bullet_scheduler

Per-frame sequencer and port arbiter for the 64-entry bullet memory (dual-port RAM, 1-cycle read latency, entry format {y[10:0], x[11:0], valid}). During active video it passes the renderer's read address through to the RAM. At each vertical-blank start it runs one scan over the table that moves live bullets up, retires off-screen bullets and fills free slots from a small queue of fire requests. It sits between the player/fire logic, the bullet renderer and the bullet RAM.

## Interface
- ADDR_W, 6: RAM address width; table depth is 2^ADDR_W.
- SPEED, 4: pixels subtracted from y per frame.
- FIFO_DEPTH, 4: fire-request queue depth (power of two).

- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- vblank  in  1  vertical blanking, level.
- fire_valid  in  1  fire request.
- fire_ready  out  1  queue can accept (= !fifo_full).
- fire_x  in  12  spawn column.
- fire_y  in  11  spawn row.
- render_addr  in  ADDR_W  renderer read address.
- mem_rd_addr  out  ADDR_W  RAM read address.
- mem_q  in  24  RAM read data (1 cycle after address).
- mem_wr_addr  out  ADDR_W  RAM write address.
- mem_wr_data  out  24  RAM write data.
- mem_wren  out  1  RAM write enable.
- busy  out  1  scan owns RAM; renderer output invalid.
- frame_done  out  1  one-cycle pulse at scan end.
- active_count  out  ADDR_W+1  valid entries after last scan.
- overrun  out  1  sticky: vblank fell while busy.

## Operation
- FSM states: IDLE, SCAN, FLUSH.
- IDLE: mem_rd_addr = render_addr; mem_wren = 0. The block registers vblank as vb_d. Condition vblank & !vb_d moves the FSM to SCAN with scan_addr = 0.
- SCAN: mem_rd_addr = scan_addr, which increments every cycle. The address issued in cycle t is held in a 1-stage pipe (pipe_valid, pipe_addr). At scan_addr = 2^ADDR_W-1 the FSM moves to FLUSH.
- Write stage, active whenever pipe_valid = 1; mem_wren = 1 and mem_wr_addr = pipe_addr:
  - mem_q valid and y ≥ SPEED: write {y-SPEED, x, 1}. The count increments.
  - mem_q valid and y < SPEED: write 24'b0 (retire).
  - mem_q invalid and FIFO non-empty: pop the FIFO and write {fire_y, fire_x, 1}. The count increments. An inserted bullet is not moved in the same frame.
  - mem_q invalid and FIFO empty: write 24'b0.
- FLUSH: performs the last write, then the block latches active_count from the running count, pulses frame_done for 1 cycle and returns to IDLE.
- busy = (state != IDLE).
- FIFO:
  - Push when fire_valid & fire_ready.
  - A push and a pop in the same cycle are both honoured.
  - When full, fire_ready = 0 even if a pop occurs that cycle.
  - A request is never dropped silently.
- Arithmetic: y compare and subtract are unsigned 11-bit; x passes through unchanged. The running count is ADDR_W+1 bits and saturates at 2^ADDR_W.
- overrun is set when vblank = 0 while busy = 1. It is cleared only by reset. The scan always completes, even if vblank ends.
- A vblank rising edge while busy is ignored; no scan is queued.

## Timing
- Reset values: state IDLE, mem_wren 0, mem_wr_addr 0, mem_wr_data 0, busy 0, frame_done 0, active_count 0, overrun 0, FIFO empty (fire_ready 1), vb_d 0. RAM contents are not cleared by reset.
- Reset mid-scan aborts the scan, with mem_wren = 0 from the next cycle. Partially updated entries remain.
- Scan timing:
  - Cycle E: first cycle with vblank = 1 and vb_d = 0.
  - E+1: first SCAN cycle, mem_rd_addr = 0.
  - E+2: first write (addr 0).
  - E+1+2^ADDR_W: FLUSH, which writes the last address.
  - Next cycle: IDLE with frame_done = 1.
  - Total busy time = 2^ADDR_W + 1 cycles (65 at default).
- fire_ready updates the cycle after a push or pop.
- A FIFO entry pushed at cycle t can be popped by a write in cycle t+1 or later.

## Test plan
- Reset, RAM zeroed, one vblank pulse:
  - 64 writes of 0.
  - frame_done exactly 66 cycles after the vblank edge.
  - active_count = 0.
- Entry 5 = {y=100, x=300, 1}, SPEED=4, three frames -> entry 5 = {88, 300, 1}; active_count = 1.
- Entry 9 with y = 3 -> after one scan entry 9 = 0; active_count decrements.
- Push 5 requests back-to-back with empty RAM, no vblank:
  - fire_ready falls after the 4th push.
  - After a scan, entries 0–3 hold the 4 requests in push order.
  - The 5th request is accepted once space frees.
- vblank falls 10 cycles into a scan -> scan completes, overrun = 1 and stays 1 until reset.
- Assert reset (0) at scan cycle 20 -> mem_wren = 0 next cycle, busy = 0, FIFO empty, active_count = 0.

Source files
------------

// File: rtl/bullet_scheduler_if.sv
// -----------------------------------------------------------------------------
// bullet_scheduler_if
// Bus bundle between the bullet scheduler and its neighbours.
//   fire_valid / fire_ready / fire_x / fire_y : fire-request handshake
//   render_addr                               : renderer read address
//   mem_rd_addr / mem_q                       : bullet RAM read port (1-cycle)
//   mem_wr_addr / mem_wr_data / mem_wren      : bullet RAM write port
// Modports:
//   master : the scheduler side
//   slave  : the surrounding logic (fire logic, renderer, RAM)
// -----------------------------------------------------------------------------
interface bullet_scheduler_if #(
  parameter int ADDR_W = 6
);
  logic              fire_valid;
  logic              fire_ready;
  logic [11:0]       fire_x;
  logic [10:0]       fire_y;
  logic [ADDR_W-1:0] render_addr;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [23:0]       mem_q;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [23:0]       mem_wr_data;
  logic              mem_wren;

  modport master (
    input  fire_valid,
    input  fire_x,
    input  fire_y,
    input  render_addr,
    input  mem_q,
    output fire_ready,
    output mem_rd_addr,
    output mem_wr_addr,
    output mem_wr_data,
    output mem_wren
  );

  modport slave (
    output fire_valid,
    output fire_x,
    output fire_y,
    output render_addr,
    output mem_q,
    input  fire_ready,
    input  mem_rd_addr,
    input  mem_wr_addr,
    input  mem_wr_data,
    input  mem_wren
  );
endinterface

// File: rtl/bullet_scheduler.sv
// -----------------------------------------------------------------------------
// bullet_scheduler
// Per-frame sequencer and port arbiter for the bullet table RAM.
// While idle the renderer's read address goes straight to the RAM. On each
// rising edge of vblank one pass over the whole table is made: live bullets
// move up by SPEED rows, bullets leaving the top are retired, and free slots
// are filled from a small queue of fire requests.
// Ports:
//   i_clock        : system clock, rising edge
//   i_reset        : synchronous reset, active low
//   i_vblank       : vertical blanking level
//   bus            : fire handshake, renderer address and RAM ports (master)
//   o_busy         : scan owns the RAM, renderer data invalid
//   o_frame_done   : one-cycle pulse after the last table write
//   o_active_count : number of valid entries after the last scan
//   o_overrun      : sticky, vblank ended while a scan was still running
// Entry format: {y[10:0], x[11:0], valid}.
// -----------------------------------------------------------------------------
module bullet_scheduler #(
  parameter int ADDR_W     = 6,
  parameter int SPEED      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_vblank,
  bullet_scheduler_if.master bus,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic [ADDR_W:0]    o_active_count,
  output logic               o_overrun
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [PTR_W:0]    PTR_ONE   = (PTR_W + 1)'(1);
  localparam logic [10:0]       SPEED_Y   = 11'(SPEED);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Build a live table entry from a position.
  function automatic logic [23:0] f_pack_entry(input logic [10:0] y, input logic [11:0] x);
    return {y, x, 1'b1};
  endfunction

  // Registers
  state_t            r_state;
  logic              r_vb_d;
  logic [ADDR_W-1:0] r_scan_addr;
  logic              r_pipe_valid;
  logic [ADDR_W-1:0] r_pipe_addr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_active_count;
  logic              r_frame_done;
  logic              r_overrun;
  logic [PTR_W:0]    r_wr_ptr;
  logic [PTR_W:0]    r_rd_ptr;
  logic [11:0]       r_fifo_x [FIFO_DEPTH];
  logic [10:0]       r_fifo_y [FIFO_DEPTH];

  // Wires
  state_t            w_state_nxt;
  logic              w_start;
  logic              w_busy;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_push;
  logic              w_pop;
  logic              w_count_inc;
  logic [ADDR_W:0]   w_count_nxt;
  logic [23:0]       w_wr_data;
  logic [10:0]       w_q_y;
  logic [11:0]       w_q_x;
  logic              w_q_valid;

  assign w_busy      = (r_state != ST_IDLE);
  // vb_d is tracked in every state, so an edge that arrives during a scan
  // is simply consumed and never starts a second pass.
  assign w_start     = i_vblank & ~r_vb_d & (r_state == ST_IDLE);

  assign w_q_y       = bus.mem_q[23:13];
  assign w_q_x       = bus.mem_q[12:1];
  assign w_q_valid   = bus.mem_q[0];

  // Pointers carry one extra wrap bit to tell full from empty.
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                        (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  // Ready comes only from registered pointers: a pop in the same cycle
  // does not open a slot until the next cycle.
  assign w_push       = bus.fire_valid & ~w_fifo_full;

  assign w_count_nxt  = (w_count_inc && (r_count != COUNT_MAX)) ? (r_count + COUNT_ONE) : r_count;

  // Outputs to the bus and status
  assign bus.fire_ready  = ~w_fifo_full;
  assign bus.mem_rd_addr = (r_state == ST_IDLE) ? bus.render_addr : r_scan_addr;
  assign bus.mem_wren    = r_pipe_valid;
  assign bus.mem_wr_addr = r_pipe_addr;
  assign bus.mem_wr_data = w_wr_data;

  assign o_busy          = w_busy;
  assign o_frame_done    = r_frame_done;
  assign o_active_count  = r_active_count;
  assign o_overrun       = r_overrun;

  // FSM state register
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_SCAN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (r_scan_addr == LAST_ADDR) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_state_nxt = ST_SCAN;
        end
      end
      ST_FLUSH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Write stage: decide the new contents of the entry whose read data is
  // arriving this cycle, and whether it draws from the fire queue.
  always_comb begin
    w_wr_data   = 24'd0;
    w_pop       = 1'b0;
    w_count_inc = 1'b0;
    if (r_pipe_valid) begin
      if (w_q_valid) begin
        if (w_q_y >= SPEED_Y) begin
          w_wr_data   = f_pack_entry(w_q_y - SPEED_Y, w_q_x);
          w_count_inc = 1'b1;
        end else begin
          w_wr_data   = 24'd0;
        end
      end else if (!w_fifo_empty) begin
        // A freshly spawned bullet keeps its spawn row for this frame.
        w_wr_data   = f_pack_entry(r_fifo_y[r_rd_ptr[PTR_W-1:0]], r_fifo_x[r_rd_ptr[PTR_W-1:0]]);
        w_pop       = 1'b1;
        w_count_inc = 1'b1;
      end else begin
        w_wr_data   = 24'd0;
      end
    end else begin
      w_wr_data = 24'd0;
    end
  end

  // Scan sequencing, read pipe, running count and status registers
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_vb_d         <= 1'b0;
      r_scan_addr    <= {ADDR_W{1'b0}};
      r_pipe_valid   <= 1'b0;
      r_pipe_addr    <= {ADDR_W{1'b0}};
      r_count        <= {(ADDR_W + 1){1'b0}};
      r_active_count <= {(ADDR_W + 1){1'b0}};
      r_frame_done   <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_vb_d       <= i_vblank;
      r_pipe_valid <= (r_state == ST_SCAN);
      r_frame_done <= (r_state == ST_FLUSH);
      r_overrun    <= r_overrun | (~i_vblank & w_busy);

      if (w_start) begin
        r_scan_addr <= {ADDR_W{1'b0}};
      end else if ((r_state == ST_SCAN) && (r_scan_addr != LAST_ADDR)) begin
        r_scan_addr <= r_scan_addr + ADDR_ONE;
      end else begin
        r_scan_addr <= r_scan_addr;
      end

      if (r_state == ST_SCAN) begin
        r_pipe_addr <= r_scan_addr;
      end else begin
        r_pipe_addr <= r_pipe_addr;
      end

      if (w_start) begin
        r_count <= {(ADDR_W + 1){1'b0}};
      end else begin
        r_count <= w_count_nxt;
      end

      // FLUSH carries the final write, so its increment is included here.
      if (r_state == ST_FLUSH) begin
        r_active_count <= w_count_nxt;
      end else begin
        r_active_count <= r_active_count;
      end
    end
  end

  // Fire-queue pointers
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_wr_ptr <= {(PTR_W + 1){1'b0}};
      r_rd_ptr <= {(PTR_W + 1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // Fire-queue storage; contents are qualified by the pointers so no reset
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_fifo_x[r_wr_ptr[PTR_W-1:0]] <= bus.fire_x;
      r_fifo_y[r_wr_ptr[PTR_W-1:0]] <= bus.fire_y;
    end
  end

endmodule

// File: tb/tb_bullet_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bullet_scheduler
// Drives bullet_scheduler with directed and random frames against a table
// model that applies the per-frame rules to a plain array and a request queue.
// -----------------------------------------------------------------------------
module tb_bullet_scheduler;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int SPEED  = 4;
  localparam int QDEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              vblank;
  logic              busy;
  logic              frame_done;
  logic              overrun;
  logic [ADDR_W:0]   active_count;

  logic              ram_clr;
  logic              poke_en;
  logic [ADDR_W-1:0] poke_addr;
  logic [23:0]       poke_data;
  logic [23:0]       ram [DEPTH];

  logic [23:0]       exp_tbl [DEPTH];
  logic [22:0]       fq [$];
  int                n_vec = 0;
  int                n_err = 0;
  int                exp_active = 0;
  int                exp_overrun = 0;

  always #5 clk = ~clk;

  bullet_scheduler_if #(.ADDR_W(ADDR_W)) bus_if ();

  bullet_scheduler #(
    .ADDR_W(ADDR_W),
    .SPEED(SPEED),
    .FIFO_DEPTH(QDEPTH)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .i_vblank(vblank),
    .bus(bus_if),
    .o_busy(busy),
    .o_frame_done(frame_done),
    .o_active_count(active_count),
    .o_overrun(overrun)
  );

  // Behavioural bullet RAM: one-cycle read, plus bench-side clear and preload
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 24'd0;
    end else if (poke_en) begin
      ram[poke_addr] <= poke_data;
    end else if (bus_if.mem_wren) begin
      ram[bus_if.mem_wr_addr] <= bus_if.mem_wr_data;
    end
    bus_if.mem_q <= ram[bus_if.mem_rd_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus_if.fire_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic poke(input int addr, input logic [23:0] data);
    poke_en   = 1'b1;
    poke_addr = ADDR_W'(addr);
    poke_data = data;
    step();
    poke_en   = 1'b0;
    exp_tbl[addr] = data;
  endtask

  // One idle cycle with an optional fire request; also checks the read
  // address passthrough with a random renderer address.
  task automatic push_cycle(input logic v, input logic [11:0] x, input logic [10:0] y);
    logic [ADDR_W-1:0] ra;
    ra = ADDR_W'($urandom);
    bus_if.fire_valid  = v;
    bus_if.fire_x      = x;
    bus_if.fire_y      = y;
    bus_if.render_addr = ra;
    #1;
    check_eq("fire_ready", 32'(bus_if.fire_ready), 32'(fq.size() < QDEPTH));
    check_eq("rd_pass", 32'(bus_if.mem_rd_addr), 32'(ra));
    if (v && (fq.size() < QDEPTH)) fq.push_back({y, x});
    step();
    bus_if.fire_valid = 1'b0;
  endtask

  // Apply one frame of the bullet rules to the expected table.
  task automatic model_frame();
    int cnt;
    logic [10:0] y;
    logic [11:0] x;
    logic [22:0] r;
    cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (exp_tbl[i][0]) begin
        y = exp_tbl[i][23:13];
        x = exp_tbl[i][12:1];
        if (int'(y) >= SPEED) begin
          exp_tbl[i] = {y - 11'(SPEED), x, 1'b1};
          cnt++;
        end else begin
          exp_tbl[i] = 24'd0;
        end
      end else if (fq.size() > 0) begin
        r = fq.pop_front();
        exp_tbl[i] = {r, 1'b1};
        cnt++;
      end else begin
        exp_tbl[i] = 24'd0;
      end
    end
    exp_active = (cnt > DEPTH) ? DEPTH : cnt;
  endtask

  // Raise vblank, follow the scan, then compare timing, counts and table.
  // drop_at > 0 lowers vblank that many cycles into the scan and raises it
  // again later while still busy (that edge must be ignored).
  task automatic run_frame(input int drop_at);
    int nwr, nbusy, done_at;
    nwr = 0; nbusy = 0; done_at = 0;
    bus_if.fire_valid = 1'b0;
    vblank = 1'b1;
    if (drop_at > 0) exp_overrun = 1;
    for (int j = 1; (j <= 200) && (done_at == 0); j++) begin
      step();
      if (busy) nbusy++;
      if (bus_if.mem_wren) begin
        check_eq("wr_addr", 32'(bus_if.mem_wr_addr), 32'(nwr));
        nwr++;
      end
      if (frame_done) done_at = j;
      if ((drop_at > 0) && (j == drop_at)) vblank = 1'b0;
      if ((drop_at > 0) && (j == drop_at + 20)) vblank = 1'b1;
    end
    vblank = 1'b0;
    check_eq("done_latency", 32'(done_at), 32'(DEPTH + 2));
    check_eq("busy_cycles", 32'(nbusy), 32'(DEPTH + 1));
    check_eq("write_count", 32'(nwr), 32'(DEPTH));
    model_frame();
    check_eq("active_count", 32'(active_count), 32'(exp_active));
    check_eq("overrun", 32'(overrun), 32'(exp_overrun));
    for (int i = 0; i < DEPTH; i++) begin
      check_eq($sformatf("entry%0d", i), 32'(ram[i]), 32'(exp_tbl[i]));
    end
    step();
    check_eq("fd_pulse", 32'(frame_done), 32'd0);
    check_eq("idle_after", 32'(busy), 32'd0);
    idle(2);
  endtask

  initial begin
    rst_n              = 1'b0;
    vblank             = 1'b0;
    bus_if.fire_valid  = 1'b0;
    bus_if.fire_x      = 12'd0;
    bus_if.fire_y      = 11'd0;
    bus_if.render_addr = {ADDR_W{1'b0}};
    ram_clr            = 1'b1;
    poke_en            = 1'b0;
    poke_addr          = {ADDR_W{1'b0}};
    poke_data          = 24'd0;
    for (int i = 0; i < DEPTH; i++) exp_tbl[i] = 24'd0;

    // Reset state
    repeat (3) step();
    ram_clr = 1'b0;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_active", 32'(active_count), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_wren", 32'(bus_if.mem_wren), 32'd0);
    check_eq("rst_wr_addr", 32'(bus_if.mem_wr_addr), 32'd0);
    check_eq("rst_wr_data", 32'(bus_if.mem_wr_data), 32'd0);
    check_eq("rst_fire_ready", 32'(bus_if.fire_ready), 32'd1);
    rst_n = 1'b1;
    idle(2);

    // Empty table, one frame
    run_frame(0);

    // Single bullet moves up three frames: 100 -> 88
    poke(5, {11'd100, 12'd300, 1'b1});
    run_frame(0);
    run_frame(0);
    run_frame(0);
    check_eq("e5_after3", 32'(ram[5]), 32'({11'd88, 12'd300, 1'b1}));

    // Bullet near the top is retired on the second frame
    poke(9, {11'd7, 12'd77, 1'b1});
    run_frame(0);
    check_eq("count_two", 32'(active_count), 32'd2);
    run_frame(0);
    check_eq("e9_retired", 32'(ram[9]), 32'd0);
    check_eq("count_back", 32'(active_count), 32'd1);

    // Five back-to-back requests: only four fit
    for (int k = 0; k < 5; k++) push_cycle(1'b1, 12'(100 + k), 11'(400 + k));
    check_eq("ready_full", 32'(bus_if.fire_ready), 32'd0);
    idle(1);
    run_frame(0);
    check_eq("e0_first", 32'(ram[0]), 32'({11'd400, 12'd100, 1'b1}));
    check_eq("e3_fourth", 32'(ram[3]), 32'({11'd403, 12'd103, 1'b1}));
    push_cycle(1'b1, 12'd104, 11'd404);
    idle(1);
    run_frame(0);

    // Random preloads and fire traffic
    for (int f = 0; f < 8; f++) begin
      for (int p = 0; p < 2; p++) begin
        poke($urandom_range(0, DEPTH - 1),
             {11'($urandom_range(0, 40)), 12'($urandom), 1'($urandom)});
      end
      for (int c = 0; c < int'($urandom_range(0, 7)); c++) begin
        push_cycle(1'($urandom), 12'($urandom), 11'($urandom_range(0, 2047)));
      end
      idle(1);
      run_frame(0);
    end

    // vblank ends early: scan still completes, overrun sticks
    push_cycle(1'b1, 12'd55, 11'd200);
    run_frame(10);
    run_frame(0);

    // Reset part-way through a scan
    push_cycle(1'b1, 12'd1, 11'd300);
    push_cycle(1'b1, 12'd2, 11'd301);
    vblank = 1'b1;
    repeat (20) step();
    rst_n = 1'b0;
    step();
    check_eq("mid_rst_wren", 32'(bus_if.mem_wren), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_ready", 32'(bus_if.fire_ready), 32'd1);
    check_eq("mid_rst_active", 32'(active_count), 32'd0);
    check_eq("mid_rst_overrun", 32'(overrun), 32'd0);
    rst_n  = 1'b1;
    vblank = 1'b0;
    fq.delete();
    step();
    check_eq("post_rst_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
